// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: per-register countdown of cycles until a pending result
// can be forwarded, driving RAW/WAW stalls and an optional multiplier structural stall.
module hazard_scoreboard #(
  parameter int LOAD_LAT      = 1,
  parameter int MUL_LAT       = 3,
  parameter int MUL_PIPELINED = 1,
  parameter int MAX_LAT       = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic        id_flush,
  input  logic [4:0]  id_rs_addr,
  input  logic [4:0]  id_rt_addr,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_reg_we,
  input  logic [4:0]  id_reg_write_addr,
  input  logic        id_is_load,
  input  logic        id_is_mul,
  output logic        stall,
  output logic        issue,
  output logic [31:0] busy_mask,
  output logic [31:0] stall_count
);

  localparam int CW = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

  generate
    if (LOAD_LAT < 0 || MUL_LAT < 0 || LOAD_LAT > MAX_LAT || MUL_LAT > MAX_LAT) begin : g_bad_lat
      $error("hazard_scoreboard: LOAD_LAT and MUL_LAT must lie in 0..MAX_LAT");
    end
  endgenerate

  logic [CW-1:0] cnt_q [32];
  logic [CW-1:0] cnt_d [32];
  logic [CW-1:0] lat;
  logic          raw;
  logic          waw;
  logic          str;
  logic          wr_en;
  logic [31:0]   stall_count_q;
  logic [31:0]   stall_count_d;

  always_comb begin
    lat = '0;
    if (id_is_load) begin
      lat = CW'(LOAD_LAT);
    end else if (id_is_mul) begin
      lat = CW'(MUL_LAT);
    end
  end

  assign raw = (id_uses_rs && (cnt_q[id_rs_addr] != '0) && (id_rs_addr != 5'd0)) ||
               (id_uses_rt && (cnt_q[id_rt_addr] != '0) && (id_rt_addr != 5'd0));
  // A pending write that lands later than this one would clobber the younger result.
  assign waw = id_reg_we && (id_reg_write_addr != 5'd0) && (cnt_q[id_reg_write_addr] > lat);

  generate
    if (MUL_PIPELINED == 0) begin : g_mul_struct
      logic [CW-1:0] mul_cnt_q;
      logic [CW-1:0] mul_cnt_d;

      always_comb begin
        mul_cnt_d = (mul_cnt_q != '0) ? mul_cnt_q - 1'b1 : mul_cnt_q;
        if (issue && id_is_mul) begin
          mul_cnt_d = CW'(MUL_LAT);
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          mul_cnt_q <= '0;
        end else begin
          mul_cnt_q <= mul_cnt_d;
        end
      end

      assign str = id_is_mul && (mul_cnt_q != '0);
    end else begin : g_mul_pipe
      assign str = 1'b0;
    end
  endgenerate

  assign stall = id_valid && !id_flush && (raw || waw || str);
  assign issue = id_valid && !id_flush && !stall;
  assign wr_en = issue && id_reg_we && (id_reg_write_addr != 5'd0);

  // A fresh write takes priority over the decrement of the same register.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - 1'b1 : cnt_q[r];
      if (wr_en && (id_reg_write_addr == 5'(r))) begin
        cnt_d[r] = lat;
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
      stall_count_q <= '0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      stall_count_q <= stall_count_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_busy
      assign busy_mask[gi] = (cnt_q[gi] != '0);
    end
  endgenerate

  assign stall_count = stall_count_q;

endmodule
